// File: rtl/onehot_scan_encoder.sv
// Serialises a captured multi-hot request vector into binary indices, lowest
// index first, one index per valid/ready handshake.
module onehot_scan_encoder #(
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [2**N-1:0] req,
  input  logic           load,
  input  logic           ready,
  output logic [N-1:0]   idx,
  output logic           valid,
  output logic           busy,
  output logic           done,
  output logic [N:0]     cnt
);

  localparam int W = 2 ** N;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    pending_q, pending_d;
  logic [N:0]      cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [N-1:0]    idx_q, idx_d;
  logic            valid_q, valid_d;

  function automatic logic [N:0] popcount(input logic [W-1:0] v);
    logic [N:0] c;
    c = '0;
    for (int i = 0; i < W; i++) begin
      c = c + (N+1)'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [N-1:0] lowest_set(input logic [W-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) r = N'(i);
    end
    return r;
  endfunction

  // Handshake: a transfer happens on a rising edge where valid=1 and ready=1.
  // While valid=1 and ready=0, idx and valid hold unchanged. valid never
  // depends combinationally on ready; idx/valid/done are all flop outputs.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          pending_d = req;
          cnt_d     = popcount(req);
          if (req != '0) state_d = SCAN;
          else           done_d  = 1'b1;
        end
      end
      SCAN: begin
        if (ready) begin
          // Clearing the lowest set bit is the same as clearing bit idx_q.
          pending_d = pending_q & (pending_q - W'(1));
          if (pending_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == SCAN);
    idx_d   = valid_d ? lowest_set(pending_d) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
    end
  end

  assign idx   = idx_q;
  assign valid = valid_q;
  assign busy  = valid_q;
  assign done  = done_q;
  assign cnt   = cnt_q;

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Randomised self-checking bench for onehot_scan_encoder (N=3), using a queue
// of expected indices built directly from the set bits of each request.
module tb_onehot_scan_encoder;

  localparam int N = 3;
  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] req;
  logic         load;
  logic         ready;
  logic [N-1:0] idx;
  logic         valid;
  logic         busy;
  logic         done;
  logic [N:0]   cnt;

  int checks;
  int errors;

  onehot_scan_encoder #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .load    (load),
    .ready   (ready),
    .idx     (idx),
    .valid   (valid),
    .busy    (busy),
    .done    (done),
    .cnt     (cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one load of r and follows the scan cycle by cycle, sampling at
  // the falling edge. Returns at the falling edge of the done cycle, or after
  // abort_after handshakes if abort_after >= 0.
  task automatic do_scan(input logic [W-1:0] r, input int ready_pct,
                         input int stall_first, input int stray_at,
                         input logic [W-1:0] stray_req, input int abort_after,
                         input string name);
    logic [N-1:0] exp_q[$];
    logic [N:0]   exp_cnt;
    logic [N-1:0] exp_idx;
    bit           exp_valid;
    bit           done_exp;
    int           cyc;
    int           hs;
    exp_q = {};
    for (int i = 0; i < W; i++) if (r[i]) exp_q.push_back(N'(i));
    exp_cnt  = (N+1)'(exp_q.size());
    done_exp = (r == '0);
    req   = r;
    load  = 1'b1;
    ready = 1'b0;
    cyc   = 0;
    hs    = 0;
    while (cyc < 200) begin
      @(negedge clk);
      load = 1'b0;
      cyc++;
      exp_valid = (exp_q.size() > 0);
      exp_idx   = exp_valid ? exp_q[0] : '0;
      checks += 5;
      if (valid !== exp_valid) begin
        errors++;
        $display("FAIL %s valid cyc %0d: got %b want %b", name, cyc, valid, exp_valid);
      end
      if (busy !== exp_valid) begin
        errors++;
        $display("FAIL %s busy cyc %0d: got %b want %b", name, cyc, busy, exp_valid);
      end
      if (idx !== exp_idx) begin
        errors++;
        $display("FAIL %s idx cyc %0d: got %0d want %0d", name, cyc, idx, exp_idx);
      end
      if (done !== done_exp) begin
        errors++;
        $display("FAIL %s done cyc %0d: got %b want %b", name, cyc, done, done_exp);
      end
      if (cnt !== exp_cnt) begin
        errors++;
        $display("FAIL %s cnt cyc %0d: got %0d want %0d", name, cyc, cnt, exp_cnt);
      end
      if (done_exp) return;
      if (abort_after >= 0 && hs == abort_after) return;
      if (cyc == stray_at && exp_q.size() > 0) begin
        load = 1'b1;
        req  = stray_req;
      end
      if (cyc <= stall_first) ready = 1'b0;
      else                    ready = ($urandom_range(0, 99) < ready_pct);
      if (exp_q.size() > 0 && ready) begin
        void'(exp_q.pop_front());
        hs++;
        done_exp = (exp_q.size() == 0);
      end else begin
        done_exp = 1'b0;
      end
    end
    errors++;
    $display("FAIL %s timeout: got no done after %0d cycles, want done", name, cyc);
  endtask

  task automatic check_cleared(input string name);
    checks += 5;
    if (idx !== '0)   begin errors++; $display("FAIL %s idx: got %0d want 0", name, idx); end
    if (valid !== 0)  begin errors++; $display("FAIL %s valid: got %b want 0", name, valid); end
    if (busy !== 0)   begin errors++; $display("FAIL %s busy: got %b want 0", name, busy); end
    if (done !== 0)   begin errors++; $display("FAIL %s done: got %b want 0", name, done); end
    if (cnt !== '0)   begin errors++; $display("FAIL %s cnt: got %0d want 0", name, cnt); end
  endtask

  task automatic test_reset();
    load = 1'b1; req = 8'h0C; ready = 1'b0;
    @(negedge clk);
    load = 1'b0;
    checks += 2;
    if (valid !== 1'b1 || idx !== 3'd2) begin
      errors++;
      $display("FAIL reset_pre: got valid %b idx %0d want 1 2", valid, idx);
    end
    if (cnt !== 4'd2) begin
      errors++;
      $display("FAIL reset_pre_cnt: got %0d want 2", cnt);
    end
    #2 reset_n = 1'b0;
    #1 check_cleared("reset_async");
    @(negedge clk);
    check_cleared("reset_held");
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    do_scan(8'b1010_0100, 100, 0, -1, 8'h00, -1, "basic");
  endtask

  task automatic test_empty();
    do_scan(8'h00, 100, 0, -1, 8'h00, -1, "empty");
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_after: got done %b valid %b want 0 0", done, valid);
    end
  endtask

  task automatic test_backpressure();
    do_scan(8'b1000_0001, 100, 3, -1, 8'h00, -1, "backpressure");
  endtask

  task automatic test_back_to_back();
    do_scan(8'hFF, 100, 0, 3, 8'h0F, -1, "full");
    do_scan(8'h10, 100, 0, -1, 8'h00, -1, "load_in_done");
  endtask

  task automatic test_reset_mid_scan();
    do_scan(8'hF0, 100, 0, -1, 8'h00, 2, "mid_scan");
    #2 reset_n = 1'b0;
    #1 check_cleared("mid_reset_async");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_cleared("mid_reset_no_done");
    do_scan(8'h02, 100, 0, -1, 8'h00, -1, "after_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] r;
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 5))
        0:       r = 8'h00;
        1:       r = 8'hFF;
        default: r = W'($urandom);
      endcase
      do_scan(r, $urandom_range(20, 100), $urandom_range(0, 2),
              $urandom_range(1, 6), W'($urandom), -1, "random");
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    req     = '0;
    load    = 1'b0;
    ready   = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared("reset_initial");
    reset_n = 1'b1;
    test_reset();
    test_basic();
    test_empty();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
